// File: rtl/mio_pkg.sv
// Shared types and address-map constants for the memory/I-O bus controller.
package mio_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, ACK, RELEASE} mio_state_e;

  localparam logic [3:0] PERIPH_SEL = 4'hF;
  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_CNT    = 2'd1;

  function automatic logic is_periph(input logic [31:0] addr);
    return addr[31:28] == PERIPH_SEL;
  endfunction

endpackage

// File: rtl/mio_periph.sv
// Peripheral space: LED register, switch input and a free-running 32-bit counter.
module mio_periph
  import mio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  offset,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic [15:0] sw,
  output logic [15:0] led
);

  logic [15:0] led_q, led_d;
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    led_d = led_q;
    cnt_d = cnt_q + 32'd1;
    if (wr_en && offset == OFF_LED) led_d = wr_data[15:0];
    // A load wins over the increment in the same cycle.
    if (wr_en && offset == OFF_CNT) cnt_d = wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q <= '0;
      cnt_q <= '0;
    end else begin
      led_q <= led_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (offset)
      OFF_LED: rd_data = {16'h0, sw};
      OFF_CNT: rd_data = cnt_q;
      default: rd_data = '0;
    endcase
  end

  assign led = led_q;

endmodule

// File: rtl/mio_bus_ctrl.sv
// Bus controller between the CPU control unit and block RAM / peripherals, with wait states
// and a single-cycle MIO_ready completion pulse.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int unsigned RAM_AW   = 10,
  parameter int unsigned RAM_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              CPU_MIO,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       cpu_data_out,
  output logic [31:0]       cpu_data_in,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_data_in,
  output logic              ram_we,
  input  logic [31:0]       ram_data_out,
  input  logic [15:0]       sw,
  output logic [15:0]       led
);

  localparam logic [3:0] WaitLast = 4'(RAM_WAIT - 1);

  mio_state_e        state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              write_q, write_d;
  logic              periph_q, periph_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              req;
  logic              busy_done;
  logic              periph_wr;
  logic [31:0]       periph_rdata;
  logic              unused_addr;

  assign req = CPU_MIO & (MemRead | MemWrite);
  // Only the word-address and selector bits are decoded.
  assign unused_addr = ^addr_bus;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    write_d   = write_q;
    periph_d  = periph_q;
    busy_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d  = BUSY;
          wcnt_d   = '0;
          addr_d   = addr_bus[RAM_AW+1:2];
          data_d   = cpu_data_out;
          write_d  = MemWrite;
          periph_d = is_periph(addr_bus);
        end
      end
      BUSY: begin
        // Dropping req here does not abort; the access always runs to ACK.
        busy_done = periph_q || (wcnt_q == WaitLast);
        if (busy_done) state_d = ACK;
        else           wcnt_d  = wcnt_q + 4'd1;
      end
      ACK:     state_d = RELEASE;
      RELEASE: if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (busy_done && !write_q) rdata_d = periph_q ? periph_rdata : ram_data_out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      write_q  <= 1'b0;
      periph_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      write_q  <= write_d;
      periph_q <= periph_d;
      rdata_q  <= rdata_d;
    end
  end

  assign periph_wr = busy_done & write_q & periph_q;

  mio_periph u_periph (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (periph_wr),
    .offset  (addr_q[1:0]),
    .wr_data (data_q),
    .rd_data (periph_rdata),
    .sw      (sw),
    .led     (led)
  );

  // In IDLE the RAM sees the live address so read data is ready by the end of BUSY.
  assign ram_addr    = (state_q == IDLE) ? addr_bus[RAM_AW+1:2] : addr_q;
  assign ram_we      = (state_q == BUSY) && (wcnt_q == 4'd0) && write_q && !periph_q;
  assign ram_data_in = data_q;
  assign MIO_ready   = (state_q == ACK);
  assign cpu_data_in = rdata_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl: one instance with RAM_WAIT=1 and one with RAM_WAIT=4.
module tb_mio_bus_ctrl;

  localparam int W1 = 1;
  localparam int W4 = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, CPU_MIO = 1'b0;
  logic [31:0] addr_bus = '0, cpu_data_out = '0;
  logic [15:0] sw = '0;

  logic [31:0] rd1, rd4, rdi1, rdi4, rdo1, rdo4;
  logic        rdy1, rdy4, we1, we4;
  logic [9:0]  ra1, ra4;
  logic [15:0] led1, led4;
  logic        mio1, mio4;

  logic [31:0] rd_o;
  logic        rdy_o, we_o;
  logic [9:0]  ra_o;
  logic [15:0] led_o;

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem4 [0:1023];

  int cyc = 0;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mio1  = CPU_MIO & ~sel;
  assign mio4  = CPU_MIO & sel;
  assign rd_o  = sel ? rd4 : rd1;
  assign rdy_o = sel ? rdy4 : rdy1;
  assign we_o  = sel ? we4 : we1;
  assign ra_o  = sel ? ra4 : ra1;
  assign led_o = sel ? led4 : led1;

  always @(posedge clk) begin
    if (we1) mem1[ra1] <= rdi1;
    rdo1 <= mem1[ra1];
    if (we4) mem4[ra4] <= rdi4;
    rdo4 <= mem4[ra4];
  end

  mio_bus_ctrl #(.RAM_AW(10), .RAM_WAIT(W1)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(mio1),
    .addr_bus(addr_bus), .cpu_data_out(cpu_data_out), .cpu_data_in(rd1), .MIO_ready(rdy1),
    .ram_addr(ra1), .ram_data_in(rdi1), .ram_we(we1), .ram_data_out(rdo1), .sw(sw), .led(led1)
  );

  mio_bus_ctrl #(.RAM_AW(10), .RAM_WAIT(W4)) dut4 (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(mio4),
    .addr_bus(addr_bus), .cpu_data_out(cpu_data_out), .cpu_data_in(rd4), .MIO_ready(rdy4),
    .ram_addr(ra4), .ram_data_in(rdi4), .ram_we(we4), .ram_data_out(rdo4), .sw(sw), .led(led4)
  );

  typedef struct {
    logic [1:0]  op;     // 0 read, 1 write, 2 read+write
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] sw;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and waits for MIO_ready, counting ram_we cycles on the way.
  task automatic txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output int wes, output logic [9:0] wa, output int ack_cyc);
    CPU_MIO      = 1'b1;
    MemRead      = (op != 2'd1);
    MemWrite     = (op != 2'd0);
    addr_bus     = a;
    cpu_data_out = d;
    lat = -1; wes = 0; wa = '0; ack_cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (we_o) begin
        wes++;
        wa = ra_o;
      end
      if (rdy_o) begin
        lat = i;
        ack_cyc = cyc;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errs++;
      $display("FAIL timeout: no MIO_ready for addr %h within 30 cycles", a);
      ack_cyc = cyc;
    end
  endtask

  task automatic finish_txn();
    MemRead = 1'b0; MemWrite = 1'b0; CPU_MIO = 1'b0;
    step();
    check("ready_one_cycle", {31'b0, rdy_o}, 32'd0);
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wes, ack, aw, ar, rel_c;
    logic [9:0] wa;
    logic       periph;

    vecs[0]  = '{2'd1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0000, 32'h0000_0000, 16'h0000};
    vecs[1]  = '{2'd0, 32'h0000_0010, 32'h0000_0000, 16'h0000, 32'hDEAD_BEEF, 16'h0000};
    vecs[2]  = '{2'd1, 32'hF000_0000, 32'h0000_A5A5, 16'h0000, 32'hDEAD_BEEF, 16'hA5A5};
    vecs[3]  = '{2'd0, 32'hF000_0000, 32'h0000_0000, 16'h1234, 32'h0000_1234, 16'hA5A5};
    vecs[4]  = '{2'd0, 32'hF000_0008, 32'h0000_0000, 16'h1234, 32'h0000_0000, 16'hA5A5};
    vecs[5]  = '{2'd1, 32'hF000_000C, 32'h0000_FFFF, 16'h1234, 32'h0000_0000, 16'hA5A5};
    vecs[6]  = '{2'd1, 32'h0000_0FFC, 32'h1234_5678, 16'h0000, 32'h0000_0000, 16'hA5A5};
    vecs[7]  = '{2'd0, 32'h1000_0FFC, 32'h0000_0000, 16'h0000, 32'h1234_5678, 16'hA5A5};
    vecs[8]  = '{2'd2, 32'h0000_0020, 32'hCAFE_F00D, 16'h0000, 32'h1234_5678, 16'hA5A5};
    vecs[9]  = '{2'd0, 32'h0000_0020, 32'h0000_0000, 16'h0000, 32'hCAFE_F00D, 16'hA5A5};
    vecs[10] = '{2'd0, 32'hF000_000C, 32'h0000_0000, 16'h0000, 32'h0000_0000, 16'hA5A5};
    vecs[11] = '{2'd0, 32'hF000_0000, 32'h0000_0000, 16'hABCD, 32'h0000_ABCD, 16'hA5A5};

    // Reset state
    addr_bus = 32'h0000_0ABC;
    repeat (3) step();
    check("rst_ready", {31'b0, rdy_o}, 32'd0);
    check("rst_we", {31'b0, we_o}, 32'd0);
    check("rst_rdata", rd_o, 32'd0);
    check("rst_led", {16'b0, led_o}, 32'd0);
    check("rst_ram_addr", {22'b0, ra_o}, 32'h2AF);
    reset = 1'b1;
    step();

    // Table-driven transactions on the RAM_WAIT=1 instance
    for (int v = 0; v < 12; v++) begin
      sw = vecs[v].sw;
      periph = (vecs[v].addr[31:28] == 4'hF);
      txn(vecs[v].op, vecs[v].addr, vecs[v].wdata, lat, wes, wa, ack);
      check($sformatf("v%0d_latency", v), 32'(lat), periph ? 32'd2 : 32'(W1 + 1));
      check($sformatf("v%0d_we_cycles", v), 32'(wes),
            (vecs[v].op != 2'd0 && !periph) ? 32'd1 : 32'd0);
      if (vecs[v].op != 2'd0 && !periph)
        check($sformatf("v%0d_we_addr", v), {22'b0, wa}, {22'b0, vecs[v].addr[11:2]});
      check($sformatf("v%0d_rdata", v), rd_o, vecs[v].exp_rd);
      check($sformatf("v%0d_led", v), {16'b0, led_o}, {16'b0, vecs[v].exp_led});
      finish_txn();
    end

    // Counter load near the top, then read back after 3 idle cycles
    txn(2'd1, 32'hF000_0004, 32'hFFFF_FFFE, lat, wes, wa, aw);
    check("cnt_wr_latency", 32'(lat), 32'd2);
    finish_txn();
    repeat (3) step();
    txn(2'd0, 32'hF000_0004, 32'h0, lat, wes, wa, ar);
    check("cnt_rd_latency", 32'(lat), 32'd2);
    check("cnt_wrapped", rd_o, 32'hFFFF_FFFE + 32'(ar - 1 - aw));
    finish_txn();

    // Request held across ACK: single completion, ram_addr stays latched in RELEASE
    txn(2'd0, 32'h0000_0010, 32'h0, lat, wes, wa, ack);
    check("hold_rdata", rd_o, 32'hDEAD_BEEF);
    addr_bus = 32'h0000_0100;
    wes = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rdy_o) wes++;
      check("hold_ram_addr_latched", {22'b0, ra_o}, 32'h4);
    end
    check("hold_extra_ready", 32'(wes), 32'd0);
    MemRead = 1'b0;
    step();
    check("hold_back_to_idle", {22'b0, ra_o}, 32'h40);
    CPU_MIO = 1'b0;
    step();

    // CPU_MIO low: request ignored
    MemRead = 1'b1; MemWrite = 1'b1; CPU_MIO = 1'b0;
    addr_bus = 32'h0000_0010; cpu_data_out = 32'h0;
    wes = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rdy_o || we_o) wes++;
    end
    check("nomio_ignored", 32'(wes), 32'd0);
    MemRead = 1'b0; MemWrite = 1'b0;
    step();
    txn(2'd0, 32'h0000_0010, 32'h0, lat, wes, wa, ack);
    check("nomio_ram_intact", rd_o, 32'hDEAD_BEEF);
    finish_txn();

    // RAM_WAIT=4 instance
    sel = 1'b1;
    step();
    txn(2'd1, 32'h0000_0040, 32'h1111_2222, lat, wes, wa, ack);
    check("w4_wr_latency", 32'(lat), 32'(W4 + 1));
    check("w4_we_cycles", 32'(wes), 32'd1);
    check("w4_we_addr", {22'b0, wa}, 32'h10);
    finish_txn();
    txn(2'd0, 32'h0000_0040, 32'h0, lat, wes, wa, ack);
    check("w4_rd_latency", 32'(lat), 32'(W4 + 1));
    check("w4_rdata", rd_o, 32'h1111_2222);
    finish_txn();
    txn(2'd1, 32'hF000_0000, 32'h0000_00C3, lat, wes, wa, ack);
    check("w4_periph_latency", 32'(lat), 32'd2);
    check("w4_led", {16'b0, led_o}, 32'h00C3);
    finish_txn();

    // Reset in the middle of a RAM write, after its ram_we cycle
    CPU_MIO = 1'b1; MemWrite = 1'b1; MemRead = 1'b0;
    addr_bus = 32'h0000_0020; cpu_data_out = 32'hA0A0_5050;
    step();
    step();
    check("rstmid_we_seen", {31'b0, we_o}, 32'd0);
    step();
    check("rstmid_busy_no_ready", {31'b0, rdy_o}, 32'd0);
    reset = 1'b0;
    addr_bus = 32'h0000_0044;
    #1;
    check("rstmid_ready", {31'b0, rdy_o}, 32'd0);
    check("rstmid_we", {31'b0, we_o}, 32'd0);
    check("rstmid_rdata", rd_o, 32'd0);
    check("rstmid_led", {16'b0, led_o}, 32'd0);
    check("rstmid_ram_addr", {22'b0, ra_o}, 32'h11);
    MemWrite = 1'b0; CPU_MIO = 1'b0;
    step();
    step();
    reset = 1'b1;
    rel_c = cyc;
    wes = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rdy_o) wes++;
    end
    check("rstmid_no_late_ready", 32'(wes), 32'd0);
    txn(2'd0, 32'h0000_0020, 32'h0, lat, wes, wa, ack);
    check("rstmid_next_latency", 32'(lat), 32'(W4 + 1));
    check("rstmid_write_kept", rd_o, 32'hA0A0_5050);
    finish_txn();
    txn(2'd0, 32'hF000_0004, 32'h0, lat, wes, wa, ack);
    check("rstmid_cnt_from_zero", rd_o, 32'(ack - 1 - rel_c));
    check("rstmid_led_still_zero", {16'b0, led_o}, 32'd0);
    finish_txn();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
